// File: rtl/silife_step_ctrl.sv
// Wishbone register block for the Game of Life engine: schedules generation
// steps (pulse, free-run, timed, N-step burst) and holds MAX7219 display settings.
module silife_step_ctrl #(
    parameter int NUM_DISPLAYS = 1,
    parameter int GEN_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 24,
    parameter int BURST_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_wb_cyc,
    input  logic                      i_wb_stb,
    input  logic                      i_wb_we,
    input  logic [31:0]               i_wb_addr,
    input  logic [31:0]               i_wb_data,
    output logic                      o_wb_ack,
    output logic [31:0]               o_wb_data,
    output logic                      o_step,
    output logic [NUM_DISPLAYS-1:0]   o_disp_enable,
    output logic [4*NUM_DISPLAYS-1:0] o_disp_brightness,
    output logic                      o_irq
);
    localparam logic [7:0] ADDR_CTRL    = 8'h00;
    localparam logic [7:0] ADDR_DISP_EN = 8'h04;
    localparam logic [7:0] ADDR_BRIGHT  = 8'h08;
    localparam logic [7:0] ADDR_PERIOD  = 8'h0C;
    localparam logic [7:0] ADDR_BURST   = 8'h10;
    localparam logic [7:0] ADDR_GEN     = 8'h14;
    localparam logic [7:0] ADDR_STATUS  = 8'h18;

    logic                      ack_reg, ack_next;
    logic [31:0]               rdata_reg, rdata_next;
    logic                      step_reg, step_next;
    logic                      irq_reg, irq_next;
    logic                      run_reg, run_next;
    logic                      timed_reg, timed_next;
    logic                      irq_en_reg, irq_en_next;
    logic                      pulse_req_reg, pulse_req_next;
    logic                      irq_pending_reg, irq_pending_next;
    logic [PERIOD_WIDTH-1:0]   period_reg, period_next;
    logic [PERIOD_WIDTH-1:0]   timer_reg, timer_next;
    logic [BURST_WIDTH-1:0]    burst_reg, burst_next;
    logic [GEN_WIDTH-1:0]      gen_reg, gen_next;
    logic [NUM_DISPLAYS-1:0]   disp_en_reg, disp_en_next;
    logic [4*NUM_DISPLAYS-1:0] bright_reg, bright_next;

    logic        accept, wr_en;
    logic [7:0]  offset;
    logic        wr_ctrl, wr_disp_en, wr_bright, wr_period, wr_burst, wr_gen, wr_status;
    logic        want, busy, fire, burst_done;
    logic [31:0] rd_mux;
    logic        unused_bits;

    // Holding ack for one cycle masks the still-asserted strobe, so a held
    // request is taken at most every other cycle.
    assign accept = i_wb_cyc & i_wb_stb & ~ack_reg;
    assign wr_en  = accept & i_wb_we;
    assign offset = i_wb_addr[7:0];

    assign wr_ctrl    = wr_en && (offset == ADDR_CTRL);
    assign wr_disp_en = wr_en && (offset == ADDR_DISP_EN);
    assign wr_bright  = wr_en && (offset == ADDR_BRIGHT);
    assign wr_period  = wr_en && (offset == ADDR_PERIOD);
    assign wr_burst   = wr_en && (offset == ADDR_BURST);
    assign wr_gen     = wr_en && (offset == ADDR_GEN);
    assign wr_status  = wr_en && (offset == ADDR_STATUS);

    assign want = run_reg | (burst_reg != '0) | pulse_req_reg;
    assign busy = want;
    assign fire = want & (~timed_reg | (timer_reg == '0));
    // A BURST write landing on the final decrement replaces the count, so it is not a completion.
    assign burst_done = fire && (burst_reg == BURST_WIDTH'(1)) && !wr_burst;

    assign unused_bits = &{1'b0, i_wb_addr[31:8], i_wb_data};

    always_comb begin
        rd_mux = '0;
        case (offset)
            ADDR_CTRL:    rd_mux[4:0] = {busy, irq_en_reg, timed_reg, 1'b0, run_reg};
            ADDR_DISP_EN: rd_mux[NUM_DISPLAYS-1:0] = disp_en_reg;
            ADDR_BRIGHT:  rd_mux[4*NUM_DISPLAYS-1:0] = bright_reg;
            ADDR_PERIOD:  rd_mux[PERIOD_WIDTH-1:0] = period_reg;
            ADDR_BURST:   rd_mux[BURST_WIDTH-1:0] = burst_reg;
            ADDR_GEN:     rd_mux[GEN_WIDTH-1:0] = gen_reg;
            ADDR_STATUS:  rd_mux[0] = irq_pending_reg;
            default:      rd_mux = '0;
        endcase
    end

    always_comb begin
        ack_next         = accept;
        rdata_next       = (accept && !i_wb_we) ? rd_mux : '0;
        step_next        = fire;
        irq_next         = irq_pending_reg & irq_en_reg;
        run_next         = run_reg;
        timed_next       = timed_reg;
        irq_en_next      = irq_en_reg;
        pulse_req_next   = pulse_req_reg;
        irq_pending_next = irq_pending_reg;
        period_next      = period_reg;
        timer_next       = '0;
        burst_next       = burst_reg;
        gen_next         = gen_reg;
        disp_en_next     = disp_en_reg;
        bright_next      = bright_reg;

        if (wr_ctrl) begin
            run_next    = i_wb_data[0];
            timed_next  = i_wb_data[2];
            irq_en_next = i_wb_data[3];
        end
        // A fresh pulse request beats the clear from a step issued on the same edge.
        if (wr_ctrl && i_wb_data[1]) begin
            pulse_req_next = 1'b1;
        end else if (fire) begin
            pulse_req_next = 1'b0;
        end

        if (timed_reg && want) begin
            timer_next = (timer_reg == '0) ? period_reg : timer_reg - PERIOD_WIDTH'(1);
        end

        if (wr_burst) begin
            burst_next = i_wb_data[BURST_WIDTH-1:0];
        end else if (fire && (burst_reg != '0)) begin
            burst_next = burst_reg - BURST_WIDTH'(1);
        end

        if (wr_gen) begin
            gen_next = i_wb_data[GEN_WIDTH-1:0];
        end else if (fire) begin
            gen_next = gen_reg + GEN_WIDTH'(1);
        end

        if (burst_done) begin
            irq_pending_next = 1'b1;
        end else if (wr_status && i_wb_data[0]) begin
            irq_pending_next = 1'b0;
        end

        if (wr_period)  period_next  = i_wb_data[PERIOD_WIDTH-1:0];
        if (wr_disp_en) disp_en_next = i_wb_data[NUM_DISPLAYS-1:0];
        if (wr_bright)  bright_next  = i_wb_data[4*NUM_DISPLAYS-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_reg         <= 1'b0;
            rdata_reg       <= '0;
            step_reg        <= 1'b0;
            irq_reg         <= 1'b0;
            run_reg         <= 1'b0;
            timed_reg       <= 1'b0;
            irq_en_reg      <= 1'b0;
            pulse_req_reg   <= 1'b0;
            irq_pending_reg <= 1'b0;
            period_reg      <= '0;
            timer_reg       <= '0;
            burst_reg       <= '0;
            gen_reg         <= '0;
            disp_en_reg     <= '0;
            bright_reg      <= {NUM_DISPLAYS{4'hF}};
        end else begin
            ack_reg         <= ack_next;
            rdata_reg       <= rdata_next;
            step_reg        <= step_next;
            irq_reg         <= irq_next;
            run_reg         <= run_next;
            timed_reg       <= timed_next;
            irq_en_reg      <= irq_en_next;
            pulse_req_reg   <= pulse_req_next;
            irq_pending_reg <= irq_pending_next;
            period_reg      <= period_next;
            timer_reg       <= timer_next;
            burst_reg       <= burst_next;
            gen_reg         <= gen_next;
            disp_en_reg     <= disp_en_next;
            bright_reg      <= bright_next;
        end
    end

    assign o_wb_ack  = ack_reg;
    assign o_wb_data = rdata_reg;
    assign o_step    = step_reg;
    assign o_irq     = irq_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DISPLAYS; gi++) begin : g_disp
            assign o_disp_enable[gi]             = disp_en_reg[gi];
            assign o_disp_brightness[4*gi +: 4]  = bright_reg[4*gi +: 4];
        end
    endgenerate
endmodule

// File: doc/silife_step_ctrl.md
Name: silife_step_ctrl

Overview:
- Wishbone-mapped control block for the Game of Life engine. It generates per-generation step strobes for the cell matrix and holds per-display enable and brightness settings for a chain of MAX7219 drivers.
- Extends the single enable/pulse control with these features:
  - timed stepping, with a programmable period;
  - N-step bursts, with a completion interrupt;
  - a generation counter;
  - a parametrised display count.
- Sits between the Wishbone bus and the matrix/display blocks. The top level decodes it for addresses i_wb_addr[23:12] == 12'h000.

Parameters:
- NUM_DISPLAYS, 1, number of chained MAX7219 displays (1..8).
- GEN_WIDTH, 16, generation counter width (1..32).
- PERIOD_WIDTH, 24, step period register width (1..32).
- BURST_WIDTH, 16, burst counter width (1..32).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_wb_cyc  in  1  Wishbone cycle
- i_wb_stb  in  1  strobe, pre-qualified by the top-level address decode
- i_wb_we  in  1  write enable
- i_wb_addr  in  32  address; bits [7:0] select the register
- i_wb_data  in  32  write data
- o_wb_ack  out  1  registered acknowledge
- o_wb_data  out  32  registered read data
- o_step  out  1  high for a cycle = matrix advances one generation at that clock edge
- o_disp_enable  out  NUM_DISPLAYS  per-display enable
- o_disp_brightness  out  4*NUM_DISPLAYS  4-bit brightness per display; display k uses bits [4k+3:4k]
- o_irq  out  1  interrupt, level-sensitive

Behaviour:
- Reset values:
  - o_wb_ack=0, o_wb_data=0, o_step=0, o_irq=0.
  - o_disp_enable all 0; o_disp_brightness all 4'hF.
  - run=0, timed=0, irq_en=0, pulse_req=0.
  - period=0, burst=0, gen=0, timer=0, irq_pending=0.
- Reset mid-burst or mid-period aborts immediately; no step or irq is issued afterwards.

Bus handshake:
- A request is accepted when cyc&stb&!o_wb_ack. o_wb_ack is high exactly one cycle later.
- This gives at most one transaction per 2 cycles and prevents double-acks on held strobes.
- Read data is valid in the ack cycle. Unmapped offsets read 0; writes to them are ignored but still acknowledged.

Registers (offset, access, contents):
- 0x00 CTRL, R/W:
  - bit0 run, bit2 timed, bit3 irq_en.
  - Writing bit1=1 requests a single step; bit1 is self-clearing and always reads 0.
  - Read also returns bit4 busy = (run | burst!=0 | pulse_req).
- 0x04 DISP_EN, R/W: bits[NUM_DISPLAYS-1:0].
- 0x08 BRIGHT, R/W: bits[4*NUM_DISPLAYS-1:0].
- 0x0C PERIOD, R/W: bits[PERIOD_WIDTH-1:0].
- 0x10 BURST, R/W:
  - Write loads the remaining-step count; read returns the remaining count.
  - Writing 0 cancels the burst and sets no irq.
- 0x14 GEN, R/W:
  - Counts issued steps and wraps modulo 2^GEN_WIDTH.
  - A write loads the value. If it coincides with a step, the written value wins.
- 0x18 STATUS: bit0 irq_pending. Writing 1 to bit0 clears it; writing 0 has no effect.
- Unused upper bits read 0.

Step scheduler (registered; o_step is driven from a flop):
- want = run | (burst!=0) | pulse_req.
- Untimed mode (timed=0): o_step <= want, so a step can occur every cycle.
- Timed mode (timed=1):
  - If want & timer==0: o_step <= 1 and timer <= period.
  - Else if timer != 0: timer <= timer-1 and o_step <= 0.
  - When want=0, timer is forced to 0.
- In timed mode, steps are therefore spaced period+1 cycles apart. The first step comes the cycle after want rises.
- When a step is issued:
  - pulse_req clears;
  - burst decrements if nonzero;
  - gen increments.
- Sources merge, at most one step per cycle. Example: a pulse concurrent with run yields one step, and both flags are satisfied.
- Burst completion: when burst goes 1→0 through a step, irq_pending <= 1.
  - If a STATUS clear coincides with completion, set wins.
  - If a BURST write coincides with a decrement, the write wins and no irq is set.
- o_irq = irq_pending & irq_en, registered.
- A pulse written while timed and timer != 0 waits for the timer to reach 0.
- Latency: a CTRL write at edge T (accepted) with run or pulse set gives o_step=1 in the cycle after edge T+1.
- Clearing run stops steps from the next scheduler decision. An o_step already registered still completes.

Test Plan:
- Reset, then read all registers → CTRL=0, DISP_EN=0, BRIGHT=4'hF per display, PERIOD=0, BURST=0, GEN=0, STATUS=0; o_step=0, o_irq=0.
- Write CTRL=0x2 twice, spaced apart → exactly 2 single-cycle o_step pulses; GEN reads 2; CTRL bit1 reads 0.
- PERIOD=3, CTRL=0x5 (timed+run) for 40 cycles → o_step pulses exactly 4 cycles apart; GEN equals the pulse count; clearing run stops the pulses.
- CTRL=0x8 (irq_en), BURST=5 untimed → 5 consecutive o_step cycles; BURST reads 0; o_irq=1 and stays high until STATUS is written with 1, then 0.
- NUM_DISPLAYS=4: write BRIGHT=0x0000_A5C3 and DISP_EN=0xA → o_disp_brightness=16'hA5C3, o_disp_enable=4'b1010; read back matches; no step activity.
- Start BURST=100 with PERIOD=10 in timed mode, assert reset after the 3rd step → all outputs return to reset values; no further steps or irq; a held stb produces ack every other cycle only.
